// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the data-RAM port arbiter.
// Holds the read-owner tag encoding and the default geometry and
// starvation limit used by ram_port_arbiter and arb_starve_ctr.
package ram_arb_pkg;

    // Who owns the read data that the RAM returns next cycle
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_VID  = 2'd2
    } owner_t;

    // Default RAM geometry: 1024 words of 32 bits
    localparam int RAM_ARB_ADDR_W = 10;
    localparam int RAM_ARB_DATA_W = 32;

    // Default number of denied video cycles before video is forced through
    localparam int RAM_ARB_STARVE_MAX = 8;

    // Counter width that covers the full legal STARVE_MAX range (1..255)
    localparam int STARVE_CNT_W = 8;

endpackage

// File: rtl/ram_arb_starve_ctr.sv
// Saturating starvation counter for the video requester.
// Counts up on inc, stops at MAX, and clears on clr or reset.
// sat is high while the count sits at MAX.
module arb_starve_ctr
    import ram_arb_pkg::*;
#(
    parameter int MAX = RAM_ARB_STARVE_MAX
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam logic [STARVE_CNT_W-1:0] MAX_V = STARVE_CNT_W'(MAX);

    logic [STARVE_CNT_W-1:0] count;

    // Count denied cycles, holding at the limit; clear wins over increment
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != MAX_V)) begin
            count <= count + STARVE_CNT_W'(1);
        end
    end

    assign sat = (count == MAX_V);

endmodule

// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter for the single-port 1024x32 data RAM.
// The CPU data port and the video tile fetcher share the RAM's single
// address/write port. Grants are combinational, and each granted read is
// tagged so that the 1-cycle RAM read data is routed back to its owner.
// Optional build macro: RAM_ARB_STARVE_GUARD_EN adds a saturating
// starvation counter that forces a video grant after STARVE_MAX
// consecutive denied video cycles. Without it, the CPU always has priority.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W     = RAM_ARB_ADDR_W,
    parameter int DATA_W     = RAM_ARB_DATA_W,
    parameter int STARVE_MAX = RAM_ARB_STARVE_MAX
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,

    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_gnt,
    output logic              vid_rvalid,
    output logic [DATA_W-1:0] vid_rdata,

    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_data_in,
    input  logic [DATA_W-1:0] ram_data_out
);

    // Reject an out-of-range starvation limit at elaboration time
    if ((STARVE_MAX < 1) || (STARVE_MAX > 255)) begin : g_bad_starve_max
        $error("ram_port_arbiter: STARVE_MAX must be in 1..255");
    end

    owner_t owner_q;
    owner_t owner_d;
    logic   reset_hold;
    logic   grant_block;
    logic   vid_force;

    // Remember that reset was high last cycle so grants stay off one more cycle
    always_ff @(posedge clk) begin
        reset_hold <= rst;
    end

    assign grant_block = rst | reset_hold;

`ifdef RAM_ARB_STARVE_GUARD_EN
    logic starve_inc;
    logic starve_clr;

    assign starve_inc = vid_req & ~vid_gnt;
    assign starve_clr = vid_gnt | ~vid_req;

    arb_starve_ctr #(
        .MAX (STARVE_MAX)
    ) u_starve_ctr (
        .clk (clk),
        .rst (rst),
        .inc (starve_inc),
        .clr (starve_clr),
        .sat (vid_force)
    );
`else
    assign vid_force = 1'b0;
`endif

    // Pick at most one winner, steer its request onto the RAM port, and
    // decide which owner tag the RAM read data will carry next cycle
    always_comb begin
        cpu_gnt     = 1'b0;
        vid_gnt     = 1'b0;
        ram_addr    = '0;
        ram_we      = 1'b0;
        ram_data_in = '0;
        owner_d     = OWN_NONE;
        if (!grant_block) begin
            if (vid_req && (vid_force || !cpu_req)) begin
                vid_gnt  = 1'b1;
                ram_addr = vid_addr;
                owner_d  = OWN_VID;
            end else if (cpu_req) begin
                cpu_gnt     = 1'b1;
                ram_addr    = cpu_addr;
                ram_we      = cpu_we;
                ram_data_in = cpu_wdata;
                owner_d     = cpu_we ? OWN_NONE : OWN_CPU;
            end
        end
    end

    // Read tag register: owner of the data the RAM presents next cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q <= OWN_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    // Route returning read data to its owner; the other side sees zero.
    // Reset suppresses a return that was in flight when reset arrived.
    always_comb begin
        cpu_rvalid = (owner_q == OWN_CPU) && !rst;
        vid_rvalid = (owner_q == OWN_VID) && !rst;
        cpu_rdata  = cpu_rvalid ? ram_data_out : '0;
        vid_rdata  = vid_rvalid ? ram_data_out : '0;
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter with a write-first RAM model.
// Grant/port behaviour is checked each cycle; read returns are checked by
// a scoreboard monitor against expectations queued when reads are granted.
// Expectations follow RAM_ARB_STARVE_GUARD_EN when it is defined.
module tb_ram_port_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt;
    logic          cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic          vid_gnt;
    logic          vid_rvalid;
    logic [DW-1:0] vid_rdata;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_data_in;
    logic [DW-1:0] ram_data_out;

    logic [DW-1:0] mem [0:1023];

    typedef struct {
        int          owner;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t exp_q[$];
    int   n_compared   = 0;
    int   n_mismatched = 0;
    int   cyc          = 0;

    ram_port_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .STARVE_MAX (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_req      (cpu_req),
        .cpu_we       (cpu_we),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_gnt      (cpu_gnt),
        .cpu_rvalid   (cpu_rvalid),
        .cpu_rdata    (cpu_rdata),
        .vid_req      (vid_req),
        .vid_addr     (vid_addr),
        .vid_gnt      (vid_gnt),
        .vid_rvalid   (vid_rvalid),
        .vid_rdata    (vid_rdata),
        .ram_addr     (ram_addr),
        .ram_we       (ram_we),
        .ram_data_in  (ram_data_in),
        .ram_data_out (ram_data_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Write-first synchronous RAM; preload happens while reset is high
    always @(posedge clk) begin
        if (rst) begin
            mem[16] <= 32'h0000_000A;
            mem[17] <= 32'h0000_000B;
        end
        if (ram_we) begin
            mem[ram_addr] <= ram_data_in;
            ram_data_out  <= ram_data_in;
        end else begin
            ram_data_out  <= mem[ram_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_compared++;
        if (act !== req) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Scoreboard monitor: pair each read return with the oldest expectation
    always @(negedge clk) begin : monitor
        exp_t e;
        if (cpu_rvalid || vid_rvalid) begin
            if (exp_q.size() == 0) begin
                n_compared++;
                n_mismatched++;
                $display("[TB] FAIL unexpected_rvalid: got cpu=%0b vid=%0b, required none (cycle %0d)",
                         cpu_rvalid, vid_rvalid, cyc);
            end else begin
                e = exp_q.pop_front();
                check("ret_owner", {30'd0, cpu_rvalid, vid_rvalid}, (e.owner == 1) ? 32'd2 : 32'd1);
                check("ret_data", (e.owner == 1) ? cpu_rdata : vid_rdata, e.data);
                check("ret_other_zero", (e.owner == 1) ? vid_rdata : cpu_rdata, 32'd0);
                check("ret_cycle", 32'(cyc), 32'(e.due));
            end
        end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
            e = exp_q.pop_front();
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL missing_rvalid: got no return, required owner %0d data 0x%0h (cycle %0d)",
                     e.owner, e.data, cyc);
        end
    end

    task automatic check_output(input string name, input bit e_cg, input bit e_vg, input bit e_we,
                                input logic [AW-1:0] e_addr, input logic [DW-1:0] e_din);
        check({name, "_cpu_gnt"}, 32'(cpu_gnt), 32'(e_cg));
        check({name, "_vid_gnt"}, 32'(vid_gnt), 32'(e_vg));
        check({name, "_ram_we"}, 32'(ram_we), 32'(e_we));
        check({name, "_ram_addr"}, 32'(ram_addr), 32'(e_addr));
        check({name, "_ram_data_in"}, ram_data_in, e_din);
    endtask

    task automatic check_quiet(input string name);
        check({name, "_cpu_rvalid"}, 32'(cpu_rvalid), 32'd0);
        check({name, "_vid_rvalid"}, 32'(vid_rvalid), 32'd0);
        check({name, "_cpu_rdata"}, cpu_rdata, 32'd0);
        check({name, "_vid_rdata"}, vid_rdata, 32'd0);
    endtask

    // Drive one cycle of requests, check the port at negedge, queue any read return
    task automatic apply_stimulus(input string name, input bit quiet,
                                  input bit cr, input bit cwe, input logic [AW-1:0] caddr,
                                  input logic [DW-1:0] cwdata, input bit vr, input logic [AW-1:0] vaddr,
                                  input bit e_cg, input bit e_vg, input bit e_we,
                                  input logic [AW-1:0] e_addr, input logic [DW-1:0] e_din,
                                  input int e_own, input logic [DW-1:0] e_data);
        exp_t e;
        cpu_req   = cr;
        cpu_we    = cwe;
        cpu_addr  = caddr;
        cpu_wdata = cwdata;
        vid_req   = vr;
        vid_addr  = vaddr;
        @(negedge clk);
        check_output(name, e_cg, e_vg, e_we, e_addr, e_din);
        if (quiet) check_quiet(name);
        if (e_own != 0) begin
            e.owner = e_own;
            e.data  = e_data;
            e.due   = cyc + 1;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string name, input int n);
        for (int i = 0; i < n; i++)
            apply_stimulus(name, 1'b0, 0, 0, 10'h0, 32'h0, 0, 10'h0, 0, 0, 0, 10'h0, 32'h0, 0, 32'h0);
    endtask

    // Both sides requesting: CPU reads 0x10, video reads 0x11
    task automatic contend(input string name, input int n);
        bit vid_wins;
        for (int k = 1; k <= n; k++) begin
`ifdef RAM_ARB_STARVE_GUARD_EN
            vid_wins = (k % 5 == 0);
`else
            vid_wins = 1'b0;
`endif
            if (vid_wins)
                apply_stimulus(name, 1'b0, 1, 0, 10'h010, 32'h0, 1, 10'h011,
                               0, 1, 0, 10'h011, 32'h0, 2, 32'h0000_000B);
            else
                apply_stimulus(name, 1'b0, 1, 0, 10'h010, 32'h0, 1, 10'h011,
                               1, 0, 0, 10'h010, 32'h0, 1, 32'h0000_000A);
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: got timeout, required $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        rst = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        vid_req = 0; vid_addr = '0;
        @(posedge clk);
        #1;
        // Reset cycles with both sides requesting: nothing may be granted
        apply_stimulus("reset", 1'b1, 1, 0, 10'h010, 32'h0, 1, 10'h011, 0, 0, 0, 10'h0, 32'h0, 0, 32'h0);
        apply_stimulus("reset", 1'b1, 1, 0, 10'h010, 32'h0, 1, 10'h011, 0, 0, 0, 10'h0, 32'h0, 0, 32'h0);
        rst = 1'b0;
        apply_stimulus("post_reset", 1'b1, 1, 0, 10'h010, 32'h0, 1, 10'h011, 0, 0, 0, 10'h0, 32'h0, 0, 32'h0);
        idle("idle", 3);

        // CPU write then read-back of the same word (write-first RAM)
        apply_stimulus("cpu_wr", 1'b0, 1, 1, 10'h005, 32'hDEAD_BEEF, 0, 10'h0,
                       1, 0, 1, 10'h005, 32'hDEAD_BEEF, 0, 32'h0);
        apply_stimulus("cpu_rd", 1'b0, 1, 0, 10'h005, 32'h0, 0, 10'h0,
                       1, 0, 0, 10'h005, 32'h0, 1, 32'hDEAD_BEEF);
        idle("drain1", 1);

        // Alternating CPU/video reads every cycle
        apply_stimulus("alt_cpu", 1'b0, 1, 0, 10'h010, 32'h0, 0, 10'h0, 1, 0, 0, 10'h010, 32'h0, 1, 32'h0000_000A);
        apply_stimulus("alt_vid", 1'b0, 0, 0, 10'h0, 32'h0, 1, 10'h011, 0, 1, 0, 10'h011, 32'h0, 2, 32'h0000_000B);
        apply_stimulus("alt_cpu", 1'b0, 1, 0, 10'h010, 32'h0, 0, 10'h0, 1, 0, 0, 10'h010, 32'h0, 1, 32'h0000_000A);
        apply_stimulus("alt_vid", 1'b0, 0, 0, 10'h0, 32'h0, 1, 10'h011, 0, 1, 0, 10'h011, 32'h0, 2, 32'h0000_000B);
        idle("drain2", 1);

        // Continuous contention
        contend("contend", 20);
        idle("drain3", 1);

        // Reset arriving while a CPU read is in flight drops the return
        apply_stimulus("inflight_rd", 1'b0, 1, 0, 10'h010, 32'h0, 0, 10'h0, 1, 0, 0, 10'h010, 32'h0, 0, 32'h0);
        rst = 1'b1;
        apply_stimulus("inflight_rst", 1'b1, 0, 0, 10'h0, 32'h0, 0, 10'h0, 0, 0, 0, 10'h0, 32'h0, 0, 32'h0);
        rst = 1'b0;
        apply_stimulus("inflight_post", 1'b1, 0, 0, 10'h0, 32'h0, 0, 10'h0, 0, 0, 0, 10'h0, 32'h0, 0, 32'h0);

        // Starve count must restart from zero after reset
        contend("contend_post_rst", 5);
        idle("drain4", 2);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
